// File: rtl/weight_loader_if.sv
// Weight stream handshake between a word source (master) and the weight loader (slave).
interface weight_loader_if #(
    parameter int BITWIDTH = 18
);
    logic [BITWIDTH-1:0] inData;
    logic                inValid;
    logic                inReady;

    modport master (output inData, output inValid, input inReady);
    modport slave  (input inData, input inValid, output inReady);
endinterface

// File: rtl/weight_loader.sv
// Packs a serial weight stream into columns and writes the X RAM, then the Y RAM.
// Optional running checksum of accepted words when WLOAD_CHECKSUM_EN is defined.
module weight_loader #(
    parameter int  INPUT_SZ        = 16,
    parameter int  HIDDEN_SZ       = 16,
    parameter int  QN              = 6,
    parameter int  QM              = 11,
    localparam int BITWIDTH        = QN + QM + 1,
    localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
    localparam int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ),
    localparam int ADDR_BITWIDTH_X = $clog2(INPUT_SZ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       startLoad,
    weight_loader_if.slave             in_if,
    output logic [ADDR_BITWIDTH_X-1:0] colAddressWrite_X,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_X,
    output logic                       writeEn_X,
    output logic [ADDR_BITWIDTH-1:0]   colAddressWrite_Y,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_Y,
    output logic                       writeEn_Y,
    output logic                       loadBusy,
    output logic                       loadDone
`ifdef WLOAD_CHECKSUM_EN
    ,output logic [BITWIDTH-1:0]       checksum
`endif
);
    localparam int COL_W = (ADDR_BITWIDTH_X > ADDR_BITWIDTH) ? ADDR_BITWIDTH_X : ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] WORD_LAST = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
    localparam logic [COL_W-1:0] X_LAST = COL_W'(INPUT_SZ - 1);
    localparam logic [COL_W-1:0] Y_LAST = COL_W'(HIDDEN_SZ - 1);

    typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]     word_q, word_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [LAYER_BITWIDTH-1:0]    pack_q, pack_d;
    logic [ADDR_BITWIDTH_X-1:0]   addr_x_q, addr_x_d;
    logic [LAYER_BITWIDTH-1:0]    data_x_q, data_x_d;
    logic                         we_x_q, we_x_d;
    logic [ADDR_BITWIDTH-1:0]     addr_y_q, addr_y_d;
    logic [LAYER_BITWIDTH-1:0]    data_y_q, data_y_d;
    logic                         we_y_q, we_y_d;
    logic                         done_q, done_d;
    logic                         loading;
    logic                         hs;
    logic                         last_col;
`ifdef WLOAD_CHECKSUM_EN
    logic [BITWIDTH-1:0]          sum_q, sum_d;
`endif

    assign loading = (state_q == LOAD_X) || (state_q == LOAD_Y);
    assign hs      = in_if.inValid & loading;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        col_d    = col_q;
        pack_d   = pack_q;
        addr_x_d = addr_x_q;
        data_x_d = data_x_q;
        addr_y_d = addr_y_q;
        data_y_d = data_y_q;
        we_x_d   = 1'b0;
        we_y_d   = 1'b0;
        last_col = 1'b0;
        // DONE is the write cycle of the last Y column, so the pulse lands one cycle after it
        done_d   = (state_q == DONE);
`ifdef WLOAD_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: if (startLoad) begin
                state_d = LOAD_X;
                word_d  = '0;
                col_d   = '0;
`ifdef WLOAD_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        if (hs) begin
            pack_d[int'(word_q)*BITWIDTH +: BITWIDTH] = in_if.inData;
            word_d = word_q + 1'b1;
`ifdef WLOAD_CHECKSUM_EN
            sum_d  = sum_q + in_if.inData;
`endif
            // Output registers take the completed column so packing continues undisturbed
            if (word_q == WORD_LAST) begin
                if (state_q == LOAD_X) begin
                    last_col = (col_q == X_LAST);
                    we_x_d   = 1'b1;
                    addr_x_d = col_q[ADDR_BITWIDTH_X-1:0];
                    data_x_d = pack_d;
                    if (last_col) state_d = LOAD_Y;
                end else begin
                    last_col = (col_q == Y_LAST);
                    we_y_d   = 1'b1;
                    addr_y_d = col_q[ADDR_BITWIDTH-1:0];
                    data_y_d = pack_d;
                    if (last_col) state_d = DONE;
                end
                col_d = last_col ? '0 : col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            col_q    <= '0;
            pack_q   <= '0;
            addr_x_q <= '0;
            data_x_q <= '0;
            we_x_q   <= 1'b0;
            addr_y_q <= '0;
            data_y_q <= '0;
            we_y_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            col_q    <= col_d;
            pack_q   <= pack_d;
            addr_x_q <= addr_x_d;
            data_x_q <= data_x_d;
            we_x_q   <= we_x_d;
            addr_y_q <= addr_y_d;
            data_y_q <= data_y_d;
            we_y_q   <= we_y_d;
            done_q   <= done_d;
`ifdef WLOAD_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign in_if.inReady     = loading;
    assign colAddressWrite_X = addr_x_q;
    assign weightMemInput_X  = data_x_q;
    assign writeEn_X         = we_x_q;
    assign colAddressWrite_Y = addr_y_q;
    assign weightMemInput_Y  = data_y_q;
    assign writeEn_Y         = we_y_q;
    assign loadBusy          = loading;
    assign loadDone          = done_q;
`ifdef WLOAD_CHECKSUM_EN
    assign checksum          = sum_q;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed steps with random words, checked against a word-index model.
module tb_weight_loader;
    localparam int I   = 16;
    localparam int H   = 16;
    localparam int BW  = 18;
    localparam int LB  = BW * H;
    localparam int XW  = I * H;
    localparam int TOT = H * (I + H);

    logic clock = 1'b0;
    logic reset;
    logic startLoad;
    logic [$clog2(I)-1:0] colAddressWrite_X;
    logic [LB-1:0]        weightMemInput_X;
    logic                 writeEn_X;
    logic [$clog2(H)-1:0] colAddressWrite_Y;
    logic [LB-1:0]        weightMemInput_Y;
    logic                 writeEn_Y;
    logic                 loadBusy;
    logic                 loadDone;
`ifdef WLOAD_CHECKSUM_EN
    logic [BW-1:0]        checksum;
`endif

    weight_loader_if #(.BITWIDTH(BW)) wif ();

    weight_loader #(.INPUT_SZ(I), .HIDDEN_SZ(H), .QN(6), .QM(11)) dut (
        .clock(clock), .reset(reset), .startLoad(startLoad), .in_if(wif),
        .colAddressWrite_X(colAddressWrite_X), .weightMemInput_X(weightMemInput_X),
        .writeEn_X(writeEn_X), .colAddressWrite_Y(colAddressWrite_Y),
        .weightMemInput_Y(weightMemInput_Y), .writeEn_Y(writeEn_Y),
        .loadBusy(loadBusy), .loadDone(loadDone)
`ifdef WLOAD_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the load is a sequence of TOT words; word n lands in column n/H at row n%H.
    int            phase = 0;   // 0 idle, 1 loading, 2 done cycle
    bit            pend_hs = 0, pend_start = 0, final_wy = 0, b2b = 0;
    int            pend_idx = 0, acc_n = 0;
    logic [BW-1:0] words[$];
    logic [BW-1:0] sum = '0;
    logic [LB-1:0] obs_x[I], obs_y[H];
    int            nwx = 0, nwy = 0, ndone = 0;

    always @(negedge clock) begin
        bit exp_wx, exp_wy, at_bound;
        if (!reset) begin
            chk("rst_we_x", writeEn_X, 0);
            chk("rst_we_y", writeEn_Y, 0);
            chk("rst_done", loadDone, 0);
            phase = 0; pend_hs = 0; pend_start = 0; final_wy = 0; acc_n = 0;
            words.delete(); sum = '0;
        end else begin
            exp_wx = pend_hs && (pend_idx % H == H - 1) && (pend_idx < XW);
            exp_wy = pend_hs && (pend_idx % H == H - 1) && (pend_idx >= XW);
            chk("we_x", writeEn_X, exp_wx);
            chk("we_y", writeEn_Y, exp_wy);
            chk("done", loadDone, final_wy);
            at_bound = writeEn_X && (colAddressWrite_X == $clog2(I)'(I - 1));
            if (writeEn_X) begin obs_x[colAddressWrite_X] = weightMemInput_X; nwx++; end
            if (writeEn_Y) begin obs_y[colAddressWrite_Y] = weightMemInput_Y; nwy++; end
            if (loadDone) ndone++;
            final_wy = exp_wy && (pend_idx == TOT - 1);
            if (phase == 2) phase = 0;
            if (pend_start) begin phase = 1; acc_n = 0; words.delete(); sum = '0; end
            if (pend_hs && pend_idx == TOT - 1) phase = 2;
            chk("busy", loadBusy, phase == 1);
            chk("ready", wif.inReady, phase == 1);
`ifdef WLOAD_CHECKSUM_EN
            chk("checksum", checksum, sum);
`endif
            pend_start = startLoad && (phase == 0);
            pend_hs    = wif.inValid && (phase == 1);
            if (pend_hs) begin
                pend_idx = acc_n;
                words.push_back(wif.inData);
                sum += wif.inData;
                acc_n++;
            end
            // Streaming without gaps, the first Y word is taken while X col I-1 is written
            if (at_bound && b2b) chk("xy_boundary_hs", pend_hs && pend_idx == XW, 1);
        end
    end

    task automatic start_load();
        for (int c = 0; c < I; c++) obs_x[c] = '0;
        for (int c = 0; c < H; c++) obs_y[c] = '0;
        nwx = 0; nwy = 0; ndone = 0;
        startLoad = 1'b1;
        @(posedge clock); #1;
        startLoad = 1'b0;
    endtask

    task automatic send(input logic [BW-1:0] d, input bit gap);
        bit acc = 0;
        if (gap) begin
            wif.inValid = 1'b0; wif.inData = BW'($urandom);
            @(posedge clock); #1;
        end
        wif.inValid = 1'b1; wif.inData = d;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = wif.inReady;
            @(posedge clock); #1;
        end
        if (!acc) begin
            n_assert++; n_fail++;
            $display("FAIL accept_timeout: word %0h not taken, required within 20 cycles", d);
        end
        wif.inValid = 1'b0;
    endtask

    // mode 0: ascending 1..n from base, 1: random, 2: all ones
    task automatic stream(input int n, input int mode, input int base, input bit gap);
        b2b = !gap;
        for (int i = 0; i < n; i++)
            send((mode == 0) ? BW'(base + i + 1) : (mode == 1) ? BW'($urandom) : BW'(1), gap);
    endtask

    task automatic check_rams(input string tag);
        logic [LB-1:0] e;
        repeat (3) @(posedge clock);
        #1;
        chk({tag, "_nwords"}, words.size(), TOT);
        for (int c = 0; c < I; c++) begin
            for (int k = 0; k < H; k++) e[k*BW +: BW] = words[c*H + k];
            chk($sformatf("%s_x%0d", tag, c), obs_x[c], e);
        end
        for (int c = 0; c < H; c++) begin
            for (int k = 0; k < H; k++) e[k*BW +: BW] = words[XW + c*H + k];
            chk($sformatf("%s_y%0d", tag, c), obs_y[c], e);
        end
        chk({tag, "_nwx"}, nwx, I);
        chk({tag, "_nwy"}, nwy, H);
        chk({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        logic [LB-1:0] e;
        reset = 1'b0; startLoad = 1'b0; wif.inValid = 1'b0; wif.inData = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_addr_x", colAddressWrite_X, 0);
        chk("rst_data_x", weightMemInput_X, 0);
        chk("rst_addr_y", colAddressWrite_Y, 0);
        chk("rst_data_y", weightMemInput_Y, 0);
        chk("rst_busy", loadBusy, 0);
        chk("rst_ready", wif.inReady, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Ascending words 1..TOT, no gaps
        start_load();
        stream(TOT, 0, 0, 0);
        check_rams("seq");
        for (int k = 0; k < H; k++) e[k*BW +: BW] = BW'(k + 1);
        chk("seq_x0_const", obs_x[0], e);
        for (int k = 0; k < H; k++) e[k*BW +: BW] = BW'(TOT - H + k + 1);
        chk("seq_y15_const", obs_y[H-1], e);

        // inValid toggling every other cycle
        start_load();
        stream(TOT, 1, 0, 1);
        check_rams("gap");

        // Reset mid-load, then a full load
        start_load();
        stream(40, 1, 0, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mid_data_x", weightMemInput_X, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        start_load();
        stream(TOT, 1, 0, 0);
        check_rams("rst");

        // inValid in IDLE, startLoad mid-load and in the DONE cycle
        wif.inValid = 1'b1; wif.inData = BW'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("idle_ready", wif.inReady, 0);
        end
        wif.inValid = 1'b0;
        start_load();
        stream(100, 1, 0, 0);
        startLoad = 1'b1;
        send(BW'($urandom), 0);
        startLoad = 1'b0;
        stream(TOT - 101, 1, 0, 0);
        startLoad = 1'b1;
        @(posedge clock); #1;
        startLoad = 1'b0;
        check_rams("ign");
        chk("ign_busy", loadBusy, 0);

`ifdef WLOAD_CHECKSUM_EN
        start_load();
        stream(TOT, 2, 0, 0);
        check_rams("ones");
        chk("ones_checksum", checksum, BW'(TOT));
        start_load();
        chk("restart_checksum", checksum, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
